// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request imem front end feeding the IF/ID register.
// Handles branch redirects, decode stalls/flushes and discarding of stale memory responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pc_srcE,
  input  logic [31:0] pc_targetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCp4D,
  output logic        validD
);

  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;

  state_t      state, stateNext;
  logic [31:0] PCF, PCFNext, PCFp4;
  logic [31:0] holdInstr, holdNext;
  logic        deliver;
  logic [31:0] deliverInstr;
  logic [31:0] instrDNext, PCDNext, PCp4DNext;
  logic        validDNext;

  assign PCFp4     = PCF + 32'd4;
  assign imem_addr = PCF;

  always_comb begin
    stateNext    = state;
    PCFNext      = PCF;
    holdNext     = holdInstr;
    deliver      = 1'b0;
    deliverInstr = imem_rdata;
    imem_req     = 1'b0;
    case (state)
      REQ: begin
        // rst gates the request so nothing is issued while reset is held
        imem_req = rst & ~pc_srcE;
        if (pc_srcE) begin
          PCFNext = pc_targetE;
        end else if (imem_req && imem_ready) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (pc_srcE) begin
          PCFNext   = pc_targetE;
          stateNext = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          if (flushD) begin
            stateNext = REQ;
          end else if (stallD) begin
            holdNext  = imem_rdata;
            stateNext = HOLD;
          end else begin
            deliver   = 1'b1;
            PCFNext   = PCFp4;
            stateNext = REQ;
          end
        end
      end
      DROP: begin
        if (pc_srcE) PCFNext = pc_targetE;
        if (imem_rvalid) stateNext = REQ;
      end
      HOLD: begin
        deliverInstr = holdInstr;
        if (pc_srcE) begin
          PCFNext   = pc_targetE;
          stateNext = REQ;
        end else if (flushD) begin
          stateNext = REQ;
        end else if (!stallD) begin
          deliver   = 1'b1;
          PCFNext   = PCFp4;
          stateNext = REQ;
        end
      end
      default: stateNext = REQ;
    endcase
  end

  // IF/ID: flush beats stall beats delivery; an idle unstalled cycle loads a bubble
  always_comb begin
    instrDNext = instrD;
    PCDNext    = PCD;
    PCp4DNext  = PCp4D;
    validDNext = validD;
    if (flushD || !stallD) begin
      instrDNext = NOP_INSTR;
      PCDNext    = '0;
      PCp4DNext  = '0;
      validDNext = 1'b0;
      if (deliver) begin
        instrDNext = deliverInstr;
        PCDNext    = PCF;
        PCp4DNext  = PCFp4;
        validDNext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      PCF       <= RESET_PC;
      holdInstr <= NOP_INSTR;
      instrD    <= NOP_INSTR;
      PCD       <= '0;
      PCp4D     <= '0;
      validD    <= 1'b0;
    end else begin
      state     <= stateNext;
      PCF       <= PCFNext;
      holdInstr <= holdNext;
      instrD    <= instrDNext;
      PCD       <= PCDNext;
      PCp4D     <= PCp4DNext;
      validD    <= validDNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a word-level program-order model predicts IF/ID deliveries,
// a separate monitor pops and compares them after every clock edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        v;
  } ifid_t;

  logic        clk, rst, stallD, flushD, pc_srcE;
  logic [31:0] pc_targetE;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, PCD, PCp4D;
  logic        validD;
  logic        imem_req2, validD2;
  logic [31:0] imem_addr2, instrD2, PCD2, PCp4D2;

  int          nCmp = 0, nBad = 0;
  int          nDel = 0;
  ifid_t       expQ[$];
  logic [31:0] expPC;
  logic        held, liveOut;
  logic        memBusy;
  int          memCnt;
  logic [31:0] memAddr;
  int unsigned lat;
  logic        randReady;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pc_srcE(pc_srcE),
    .pc_targetE(pc_targetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrD), .PCD(PCD), .PCp4D(PCp4D), .validD(validD)
  );

  // Shadows the main DUT's inputs; only its first delivery (near the top of memory) is checked.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pc_srcE(pc_srcE),
    .pc_targetE(pc_targetE), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrD2), .PCD(PCD2), .PCp4D(PCp4D2), .validD(validD2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00a0_0113;
      32'h0000_0008: return 32'h0020_8193;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  function automatic ifid_t bubble();
    ifid_t b;
    b.instr = NOP;
    b.pc    = '0;
    b.pcp4  = '0;
    b.v     = 1'b0;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-order model: a word reaching decode must belong to expPC; redirects retarget expPC,
  // flushes drop the word on offer, stalls park it, and responses to abandoned requests are dead.
  task automatic modelStep();
    logic avail;
    if (!rst) return;
    if (pc_srcE) chk1("req_low_on_redirect", imem_req, 1'b0);
    if (imem_req) chk("fetch_addr", imem_addr, expPC);
    avail = held || (imem_rvalid && liveOut);
    if (imem_rvalid) liveOut = 1'b0;
    if (pc_srcE) begin
      expPC   = pc_targetE;
      held    = 1'b0;
      liveOut = 1'b0;
    end else if (avail) begin
      if (flushD) held = 1'b0;
      else if (stallD) held = 1'b1;
      else begin
        expQ.push_back('{instr: memWord(expPC), pc: expPC, pcp4: expPC + 32'd4, v: 1'b1});
        expPC = expPC + 32'd4;
        held  = 1'b0;
        nDel++;
      end
    end
    if (imem_req && imem_ready) begin
      liveOut = 1'b1;
      memBusy = 1'b1;
      memAddr = imem_addr;
      memCnt  = int'(lat);
    end
  endtask

  task automatic memDrive();
    imem_rvalid = 1'b0;
    if (randReady) imem_ready = ($urandom_range(0, 3) != 0);
    if (memBusy) begin
      memCnt--;
      if (memCnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(memAddr);
        memBusy     = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #2;
    memDrive();
  endtask

  task automatic doReset();
    rst = 1'b0; stallD = 1'b0; flushD = 1'b0; pc_srcE = 1'b0; pc_targetE = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; memBusy = 1'b0; randReady = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
    chk("rst_instrD", instrD, NOP);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCp4D", PCp4D, 32'h0);
    chk1("rst_validD", validD, 1'b0);
    expPC = 32'h0; held = 1'b0; liveOut = 1'b0;
    expQ.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("first_req_after_reset", imem_req, 1'b1);
  endtask

  // Monitor: tracks the expected IF/ID contents and compares after every edge
  initial begin
    ifid_t e;
    e = bubble();
    forever begin
      @(posedge clk);
      #1;
      if (!rst) e = bubble();
      else begin
        if (flushD) e = bubble();
        else if (!stallD) e = (expQ.size() > 0) ? expQ.pop_front() : bubble();
        chk("instrD", instrD, e.instr);
        chk("PCD", PCD, e.pc);
        chk("PCp4D", PCp4D, e.pcp4);
        chk1("validD", validD, e.v);
      end
    end
  end

  initial begin
    logic found;
    lat = 1;

    // back-to-back stream with single-cycle latency; shadow DUT wraps past 0xFFFFFFFC
    doReset();
    imem_ready = 1'b1; lat = 1;
    tick(); tick();
    chk("wrap_PCD", PCD2, 32'hFFFF_FFFC);
    chk("wrap_PCp4D", PCp4D2, 32'h0);
    chk("wrap_instrD", instrD2, 32'h0050_0093);
    chk1("wrap_validD", validD2, 1'b1);
    chk("wrap_next_addr", imem_addr2, 32'h0);
    repeat (6) tick();

    // stall over a returning word: park in hold buffer, release after three cycles
    doReset();
    imem_ready = 1'b1; lat = 1;
    tick();
    stallD = 1'b1;
    tick(); tick();
    chk("hold_addr_frozen", imem_addr, 32'h0);
    tick();
    stallD = 1'b0;
    tick();
    chk("hold_pc_advanced_once", imem_addr, 32'h4);
    repeat (3) tick();

    // redirect while waiting: late response dropped, refetch from target
    doReset();
    imem_ready = 1'b1; lat = 4;
    tick();
    pc_srcE = 1'b1; pc_targetE = 32'h100;
    tick();
    pc_srcE = 1'b0;
    #1;
    chk1("drop_no_req", imem_req, 1'b0);
    found = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (imem_req) begin
        found = 1'b1;
        break;
      end
    end
    chk1("drop_req_resumes", found, 1'b1);
    chk("drop_target_addr", imem_addr, 32'h100);
    lat = 1;
    repeat (4) tick();

    // flush and redirect together with data arriving
    doReset();
    imem_ready = 1'b1; lat = 1;
    tick();
    flushD = 1'b1; pc_srcE = 1'b1; pc_targetE = 32'h200;
    tick();
    flushD = 1'b0; pc_srcE = 1'b0;
    #1;
    chk("flush_instrD", instrD, NOP);
    chk1("flush_validD", validD, 1'b0);
    chk1("flush_req", imem_req, 1'b1);
    chk("flush_target_addr", imem_addr, 32'h200);
    repeat (4) tick();

    // memory not ready for four cycles: request and address held
    doReset();
    imem_ready = 1'b0; lat = 2;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk1("notready_req", imem_req, 1'b1);
      chk("notready_addr", imem_addr, 32'h0);
    end
    imem_ready = 1'b1;
    repeat (5) tick();

    // reset mid-transaction, then a stale response with no new acceptance
    doReset();
    imem_ready = 1'b1; lat = 5;
    tick(); tick();
    doReset();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b1; lat = 1;
    repeat (6) tick();

    // randomized traffic
    doReset();
    randReady = 1'b1;
    nDel = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      lat        = $urandom_range(1, 4);
      stallD     = ($urandom_range(0, 3) == 0);
      flushD     = ($urandom_range(0, 9) == 0);
      pc_srcE    = ($urandom_range(0, 11) == 0);
      pc_targetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
      tick();
    end
    stallD = 1'b0; flushD = 1'b0; pc_srcE = 1'b0;
    repeat (10) tick();
    chk1("random_progress", nDel > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
